// File: rtl/vga_sync_if.sv
// -----------------------------------------------------------------------------
// vga_sync_if
//
// Pixel-timing bundle produced by vga_sync and consumed by the graphics pixel
// generator and the DAC/connector pins.
//
// Signals:
//   hsync       horizontal sync, active-low
//   vsync       vertical sync, active-low
//   video_on    high while the current pixel is in the visible area
//   pix_x       current column, 0..H_TOTAL-1
//   pix_y       current line, 0..V_TOTAL-1
//   pix_tick    pixel enable, high on alternate clock_50 cycles
//   frame_start high while (pix_x, pix_y) = (0, 0)
//
// Handshake: there is no valid/ready pair on this bundle. The timing generator
// is the sole master and drives every signal on every clock_50 cycle; a
// consumer may sample any signal on any clock_50 edge. pix_x, pix_y and
// video_on are stable across both cycles of a pixel.
//
// Modports:
//   master  the timing generator (drives everything)
//   slave   a consumer (samples everything)
// -----------------------------------------------------------------------------
interface vga_sync_if;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       pix_tick;
    logic       frame_start;

    modport master (
        output hsync,
        output vsync,
        output video_on,
        output pix_x,
        output pix_y,
        output pix_tick,
        output frame_start
    );

    modport slave (
        input hsync,
        input vsync,
        input video_on,
        input pix_x,
        input pix_y,
        input pix_tick,
        input frame_start
    );
endinterface

// File: rtl/vga_sync.sv
// -----------------------------------------------------------------------------
// vga_sync
//
// Timing generator for 640x480 @ 60 Hz VGA, running from the 50 MHz board
// clock with an internally derived 25 MHz pixel enable.
//
// Ports:
//   clock_50   in   sole clock, all state updates on its rising edge
//   reset_n    in   asynchronous reset, active-low
//   vga        vga_sync_if.master
//                   hsync, vsync (active-low), video_on, pix_x, pix_y,
//                   pix_tick, frame_start
//
// Parameters: H_DISPLAY/H_FP/H_SYNC/H_BP and V_DISPLAY/V_FP/V_SYNC/V_BP give
// the line and frame geometry in pixels and lines. Both totals must be at
// most 1024 because the counters are 10 bits wide.
//
// Optional build macro:
//   VGA_SYNC_DELAY_EN  hsync/vsync pass through one extra register stage that
//                      updates on every clock_50 edge, to line sync up with
//                      RGB that the pixel generator registers one clock_50
//                      cycle after video_on/pix_x/pix_y. All other outputs
//                      are unaffected.
//
// Behaviour summary:
//   - A tick register toggles every edge; pix_tick is that register.
//   - On an edge where the tick is 1, the column counter advances and wraps
//     at the end of the line; the line counter advances on that wrap and
//     wraps at the end of the frame.
//   - hsync, vsync, video_on and frame_start are registers that load the
//     decode of the *next* counter values on the same advancing edge, so the
//     coordinates and the decoded flags always change together and the
//     decoded outputs are glitch-free.
//   - Reset leaves the decode registers at their idle values, so pixel (0,0)
//     of the first frame after reset is blanked; from the second frame on
//     every frame is complete.
// -----------------------------------------------------------------------------
module vga_sync #(
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clock_50,
    input  logic       reset_n,
    vga_sync_if.master vga
);

    // -------------------------------------------------------------------------
    // Geometry, pre-sized to the 10-bit counter width so every compare below
    // is between equal-width operands.
    // -------------------------------------------------------------------------
    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic       tick_q;          // pixel enable, toggles every edge
    logic [9:0] h_q;             // column counter
    logic [9:0] v_q;             // line counter
    logic       hsync_q;         // decoded, registered sync/flags
    logic       vsync_q;
    logic       video_on_q;
    logic       frame_start_q;

    // -------------------------------------------------------------------------
    // Next counter values and their decode
    // -------------------------------------------------------------------------
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       hsync_nxt;
    logic       vsync_nxt;
    logic       video_on_nxt;
    logic       frame_start_nxt;

    // Counter successor: the column wraps at the end of the line and only
    // that wrap moves the line counter on.
    always_comb begin
        h_nxt = h_q + 10'd1;
        v_nxt = v_q;
        if (h_q == H_LAST) begin
            h_nxt = '0;
            if (v_q == V_LAST) begin
                v_nxt = '0;
            end else begin
                v_nxt = v_q + 10'd1;
            end
        end
    end

    // Decode of the *next* position. Registering this on the advancing edge
    // means the flags describe the same pixel as pix_x/pix_y right after it.
    always_comb begin
        video_on_nxt    = (h_nxt < H_VIS) && (v_nxt < V_VIS);
        hsync_nxt       = !((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST));
        vsync_nxt       = !((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST));
        frame_start_nxt = (h_nxt == '0) && (v_nxt == '0);
    end

    // -------------------------------------------------------------------------
    // Tick, counters and decode registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            tick_q        <= 1'b0;
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            tick_q <= ~tick_q;
            // Advance only on edges where the tick is high; on the other
            // edges everything except the tick holds.
            if (tick_q) begin
                h_q           <= h_nxt;
                v_q           <= v_nxt;
                hsync_q       <= hsync_nxt;
                vsync_q       <= vsync_nxt;
                video_on_q    <= video_on_nxt;
                frame_start_q <= frame_start_nxt;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign vga.pix_tick    = tick_q;
    assign vga.pix_x       = h_q;
    assign vga.pix_y       = v_q;
    assign vga.video_on    = video_on_q;
    assign vga.frame_start = frame_start_q;

`ifdef VGA_SYNC_DELAY_EN
    // One extra stage on sync only, updated every edge (not just on ticks),
    // so sync lags the coordinates by exactly one clock_50 cycle.
    logic hsync_d;
    logic vsync_d;

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            hsync_d <= 1'b1;
            vsync_d <= 1'b1;
        end else begin
            hsync_d <= hsync_q;
            vsync_d <= vsync_q;
        end
    end

    assign vga.hsync = hsync_d;
    assign vga.vsync = vsync_d;
`else
    // Sync is coincident with pix_x/pix_y.
    assign vga.hsync = hsync_q;
    assign vga.vsync = vsync_q;
`endif

endmodule

// File: tb/tb_vga_sync.sv
// -----------------------------------------------------------------------------
// tb_vga_sync
//
// Two instances share one clock: u_big uses the default 640x480 geometry
// (line-level timing, reset behaviour), u_small uses a tiny geometry so that
// several whole frames fit in a short run (frame-level timing, visible count,
// mid-frame reset). Every cycle both are compared against a reference that
// derives the expected outputs from the number of clock edges since reset
// release with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_vga_sync;

    // -------------------------------------------------------------------------
    // Geometry
    // -------------------------------------------------------------------------
    typedef struct packed {
        int hd; int hf; int hs; int hb;
        int vd; int vf; int vs; int vb;
    } tim_t;

    typedef struct packed {
        int x; int y;
        bit hs; bit vs; bit vid; bit fs; bit tick;
    } exp_t;

    localparam int S_HD = 8, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int S_VD = 6, S_VF = 1, S_VS = 2, S_VB = 1;

    localparam tim_t BIG = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam tim_t SML = '{S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB};

    localparam int B_HT = 800;
    localparam int S_HT = S_HD + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VD + S_VF + S_VS + S_VB;

`ifdef VGA_SYNC_DELAY_EN
    localparam int SYNC_LAG = 1;
`else
    localparam int SYNC_LAG = 0;
`endif

    // -------------------------------------------------------------------------
    // Clock / reset / DUTs
    // -------------------------------------------------------------------------
    logic clock_50 = 1'b0;
    logic reset_n;
    logic reset_n_s;

    always #10 clock_50 = ~clock_50;

    vga_sync_if big_if ();
    vga_sync_if sml_if ();

    vga_sync u_big (
        .clock_50 (clock_50),
        .reset_n  (reset_n),
        .vga      (big_if)
    );

    vga_sync #(
        .H_DISPLAY (S_HD), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
        .V_DISPLAY (S_VD), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB)
    ) u_small (
        .clock_50 (clock_50),
        .reset_n  (reset_n_s),
        .vga      (sml_if)
    );

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs k clock edges after reset release (k=0: in reset).
    // Advances happen on the even edges, so k/2 pixels have elapsed. The
    // decode registers keep their reset values until the first advance.
    function automatic exp_t ref_at(input tim_t p, input int k);
        exp_t e;
        int   ht, vt, a;
        ht     = p.hd + p.hf + p.hs + p.hb;
        vt     = p.vd + p.vf + p.vs + p.vb;
        a      = k / 2;
        e.x    = a % ht;
        e.y    = (a / ht) % vt;
        e.tick = (k % 2) == 1;
        if (a == 0) begin
            e.hs = 1'b1; e.vs = 1'b1; e.vid = 1'b0; e.fs = 1'b0;
        end else begin
            e.vid = (e.x < p.hd) && (e.y < p.vd);
            e.hs  = !((e.x >= p.hd + p.hf) && (e.x < p.hd + p.hf + p.hs));
            e.vs  = !((e.y >= p.vd + p.vf) && (e.y < p.vd + p.vf + p.vs));
            e.fs  = (e.x == 0) && (e.y == 0);
        end
        return e;
    endfunction

    task automatic check_inst(input string pre, input tim_t p, input int k,
                              input logic [9:0] x, input logic [9:0] y,
                              input logic hs, input logic vs, input logic vid,
                              input logic fs, input logic tick);
        exp_t e, d;
        e = ref_at(p, k);
        d = ref_at(p, (k > 0) ? k - SYNC_LAG : 0);
        check({pre, "_pix_x"},       32'(x),    32'(e.x));
        check({pre, "_pix_y"},       32'(y),    32'(e.y));
        check({pre, "_pix_tick"},    32'(tick), 32'(e.tick));
        check({pre, "_video_on"},    32'(vid),  32'(e.vid));
        check({pre, "_frame_start"}, 32'(fs),   32'(e.fs));
        check({pre, "_hsync"},       32'(hs),   32'(d.hs));
        check({pre, "_vsync"},       32'(vs),   32'(d.vs));
        if ((int'(x) >= p.hd) || (int'(y) >= p.vd))
            check({pre, "_blank_region"}, 32'(vid), 32'd0);
    endtask

    // -------------------------------------------------------------------------
    // Per-cycle monitor (sampled 1 time unit after each rising edge) and
    // event recording for the period checks.
    // -------------------------------------------------------------------------
    int k_big = 0;
    int k_sml = 0;
    int cyc   = 0;

    int wrap_q[$], hs_fall_q[$], hs_rise_q[$], x656_q[$];
    int fs_q[$], vs_fall_q[$], vs_rise_q[$], vis_q[$];
    int vis_cnt = 0;

    logic [9:0] prev_bx  = '0;
    logic       prev_bhs = 1'b1;
    logic       prev_sfs = 1'b0;
    logic       prev_svs = 1'b1;

    always @(posedge clock_50) begin
        k_big = reset_n   ? k_big + 1 : 0;
        k_sml = reset_n_s ? k_sml + 1 : 0;
        cyc++;
        #1;
        check_inst("big", BIG, k_big, big_if.pix_x, big_if.pix_y, big_if.hsync,
                   big_if.vsync, big_if.video_on, big_if.frame_start, big_if.pix_tick);
        check_inst("sml", SML, k_sml, sml_if.pix_x, sml_if.pix_y, sml_if.hsync,
                   sml_if.vsync, sml_if.video_on, sml_if.frame_start, sml_if.pix_tick);

        if (reset_n) begin
            if (prev_bx == 10'd799 && big_if.pix_x == 10'd0) wrap_q.push_back(cyc);
            if (prev_bx != 10'd656 && big_if.pix_x == 10'd656) x656_q.push_back(cyc);
            if (prev_bhs && !big_if.hsync) hs_fall_q.push_back(cyc);
            if (!prev_bhs && big_if.hsync) hs_rise_q.push_back(cyc);
        end

        if (!reset_n_s) begin
            vis_cnt = 0;
        end else begin
            if (!prev_sfs && sml_if.frame_start) begin
                fs_q.push_back(cyc);
                vis_q.push_back(vis_cnt);
                vis_cnt = 0;
            end
            if (prev_svs && !sml_if.vsync) vs_fall_q.push_back(cyc);
            if (!prev_svs && sml_if.vsync) vs_rise_q.push_back(cyc);
            if (sml_if.video_on && sml_if.pix_tick) vis_cnt++;
        end

        prev_bx  = big_if.pix_x;
        prev_bhs = big_if.hsync;
        prev_sfs = sml_if.frame_start;
        prev_svs = sml_if.vsync;
    end

    // -------------------------------------------------------------------------
    // Period checks on recorded events
    // -------------------------------------------------------------------------
    task automatic check_big_events();
        int n;
        check("big_line_wraps_seen", 32'(wrap_q.size() >= 2), 32'd1);
        for (int i = 1; i < wrap_q.size(); i++)
            check("big_line_period", wrap_q[i] - wrap_q[i-1], 2 * B_HT);
        n = (hs_fall_q.size() < hs_rise_q.size()) ? hs_fall_q.size() : hs_rise_q.size();
        check("big_hsync_pulses_seen", 32'(n >= 2), 32'd1);
        for (int i = 0; i < n; i++)
            check("big_hsync_low_cycles", hs_rise_q[i] - hs_fall_q[i], 2 * 96);
        n = (hs_fall_q.size() < x656_q.size()) ? hs_fall_q.size() : x656_q.size();
        for (int i = 0; i < n; i++)
            check("big_hsync_fall_lag", hs_fall_q[i] - x656_q[i], SYNC_LAG);
        wrap_q.delete(); x656_q.delete(); hs_fall_q.delete(); hs_rise_q.delete();
    endtask

    task automatic check_sml_events();
        int n;
        check("sml_frames_seen", 32'(fs_q.size() >= 3), 32'd1);
        for (int i = 1; i < fs_q.size(); i++)
            check("sml_frame_period", fs_q[i] - fs_q[i-1], 2 * S_HT * S_VT);
        n = (vs_fall_q.size() < vs_rise_q.size()) ? vs_fall_q.size() : vs_rise_q.size();
        check("sml_vsync_pulses_seen", 32'(n >= 2), 32'd1);
        for (int i = 0; i < n; i++)
            check("sml_vsync_low_cycles", vs_rise_q[i] - vs_fall_q[i], 2 * S_VS * S_HT);
        // First window covers the post-reset frame whose pixel (0,0) is blanked.
        for (int i = 0; i < vis_q.size(); i++)
            check("sml_visible_count", vis_q[i], (i == 0) ? S_HD * S_VD - 1 : S_HD * S_VD);
        fs_q.delete(); vis_q.delete(); vs_fall_q.delete(); vs_rise_q.delete();
    endtask

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic run(input int n);
        repeat (n) @(negedge clock_50);
    endtask

    task automatic check_reset_values(input string pre, input logic [9:0] x, input logic [9:0] y,
                                      input logic hs, input logic vs, input logic vid,
                                      input logic fs, input logic tick);
        check({pre, "_rst_pix_x"},       32'(x),    32'd0);
        check({pre, "_rst_pix_y"},       32'(y),    32'd0);
        check({pre, "_rst_hsync"},       32'(hs),   32'd1);
        check({pre, "_rst_vsync"},       32'(vs),   32'd1);
        check({pre, "_rst_video_on"},    32'(vid),  32'd0);
        check({pre, "_rst_frame_start"}, 32'(fs),   32'd0);
        check({pre, "_rst_pix_tick"},    32'(tick), 32'd0);
    endtask

    // Wait (bounded) for the big instance to reach column tx on a line other
    // than 0, then pulse reset for one cycle.
    task automatic pulse_big_at(input int tx);
        bit found = 1'b0;
        for (int i = 0; i < 4 * B_HT && !found; i++) begin
            @(negedge clock_50);
            if (int'(big_if.pix_x) == tx && big_if.pix_y != 10'd0) found = 1'b1;
        end
        check("big_mid_reset_target_reached", 32'(found), 32'd1);
        check_big_events();
        reset_n = 1'b0;
        #1;
        check_reset_values("big_mid", big_if.pix_x, big_if.pix_y, big_if.hsync, big_if.vsync,
                           big_if.video_on, big_if.frame_start, big_if.pix_tick);
        @(negedge clock_50);
        reset_n = 1'b1;
    endtask

    task automatic pulse_sml_at(input int tx, input int ty);
        bit found = 1'b0;
        for (int i = 0; i < 4 * S_HT * S_VT && !found; i++) begin
            @(negedge clock_50);
            if (int'(sml_if.pix_x) == tx && int'(sml_if.pix_y) == ty) found = 1'b1;
        end
        check("sml_mid_reset_target_reached", 32'(found), 32'd1);
        check_sml_events();
        reset_n_s = 1'b0;
        #1;
        check_reset_values("sml_mid", sml_if.pix_x, sml_if.pix_y, sml_if.hsync, sml_if.vsync,
                           sml_if.video_on, sml_if.frame_start, sml_if.pix_tick);
        @(negedge clock_50);
        reset_n_s = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        reset_n   = 1'b0;
        reset_n_s = 1'b0;
        run(5);
        #1;
        check_reset_values("big", big_if.pix_x, big_if.pix_y, big_if.hsync, big_if.vsync,
                           big_if.video_on, big_if.frame_start, big_if.pix_tick);
        check_reset_values("sml", sml_if.pix_x, sml_if.pix_y, sml_if.hsync, sml_if.vsync,
                           sml_if.video_on, sml_if.frame_start, sml_if.pix_tick);
        reset_n   = 1'b1;
        reset_n_s = 1'b1;

        // Edge 1: tick only. Edge 2: column 1 and video_on.
        @(posedge clock_50); #2;
        check("edge1_pix_x",    32'(big_if.pix_x),    32'd0);
        check("edge1_pix_tick", 32'(big_if.pix_tick), 32'd1);
        check("edge1_video_on", 32'(big_if.video_on), 32'd0);
        @(posedge clock_50); #2;
        check("edge2_pix_x",    32'(big_if.pix_x),    32'd1);
        check("edge2_video_on", 32'(big_if.video_on), 32'd1);
        check("edge2_pix_tick", 32'(big_if.pix_tick), 32'd0);

        // Three-plus lines on the big instance, many frames on the small one.
        run(3 * 2 * B_HT + $urandom_range(0, 400));

        // Mid-frame resets at random positions.
        pulse_big_at($urandom_range(600, 799));
        pulse_sml_at($urandom_range(0, S_HT - 1), $urandom_range(1, S_VT - 1));

        run(3 * 2 * B_HT + $urandom_range(0, 400));
        check_big_events();
        check_sml_events();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
